// File: rtl/pe_seq_ctrl.sv
// Phase sequencer and output-forwarding stage for the complex-data PE.
// Runs LOAD -> COMPUTE -> TRANSMIT iterations and a final OUTPUT phase.
// Captures ALU results into the dout_tx / dout_pe registers, which have
// valid/ready backpressure.
module pe_seq_ctrl #(
  parameter int DATA_W    = 32,
  parameter int LOAD_NUM  = 16,
  parameter int INST_NUM  = 64,
  parameter int TX_NUM    = 4,
  parameter int ALPHA_NUM = 4,
  parameter int ITER_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_pe_v,
  input  logic [ITER_W-1:0] iter_num,
  input  logic              alu_v,
  input  logic [DATA_W-1:0] dout_alu,
  input  logic              tx_ready,
  input  logic              out_ready,
  output logic              busy,
  output logic              load_v,
  output logic              cmpt_v,
  output logic              tx_ph,
  output logic              out_ph,
  output logic              alu_hold,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              dout_tx_v,
  output logic [DATA_W-1:0] dout_tx,
  output logic              dout_pe_v,
  output logic [DATA_W-1:0] dout_pe,
  output logic              done
);

  localparam int MAX_LC = (LOAD_NUM > INST_NUM) ? LOAD_NUM : INST_NUM;
  localparam int MAX_TA = (TX_NUM > ALPHA_NUM) ? TX_NUM : ALPHA_NUM;
  localparam int MAX_N  = (MAX_LC > MAX_TA) ? MAX_LC : MAX_TA;
  localparam int CNT_W  = $clog2(MAX_N + 1);

  // Terminal values of the shared phase counter
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_NUM - 1);
  localparam logic [CNT_W-1:0] INST_LAST  = CNT_W'(INST_NUM - 1);
  localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_NUM - 1);
  localparam logic [CNT_W-1:0] ALPHA_LAST = CNT_W'(ALPHA_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_TRANSMIT,
    S_OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0] last_q, last_d;
  logic              done_q, done_d;
  logic              tx_v_q, tx_v_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              pe_v_q, pe_v_d;
  logic [DATA_W-1:0] pe_data_q, pe_data_d;

  logic take_tx;
  logic take_pe;

  // A target register is free when it is empty or being drained this cycle
  assign take_tx = (state_q == S_TRANSMIT) && alu_v && (!tx_v_q || tx_ready);
  assign take_pe = (state_q == S_OUTPUT)   && alu_v && (!pe_v_q || out_ready);

  // Next-state, counters and output-register capture/drain
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iter_cnt_d = iter_cnt_q;
    last_d     = last_q;
    done_d     = 1'b0;
    tx_v_d     = tx_v_q;
    tx_data_d  = tx_data_q;
    pe_v_d     = pe_v_q;
    pe_data_d  = pe_data_q;

    case (state_q)
      S_IDLE: begin
        // A pending final word blocks a new run so it cannot be overwritten
        if (din_pe_v && !pe_v_q) begin
          state_d    = S_LOAD;
          cnt_d      = '0;
          iter_cnt_d = '0;
          last_d     = (iter_num == '0) ? '0 : iter_num - ITER_W'(1);
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt_q == INST_LAST) begin
          cnt_d   = '0;
          state_d = (iter_cnt_q == last_q) ? S_OUTPUT : S_TRANSMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TRANSMIT: begin
        if (take_tx) begin
          if (cnt_q == TX_LAST) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            if (iter_cnt_q != last_q) iter_cnt_d = iter_cnt_q + ITER_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUTPUT: begin
        if (take_pe) begin
          if (cnt_q == ALPHA_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A take wins over a drain, so simultaneous take+drain keeps valid high
    if (take_tx) begin
      tx_v_d    = 1'b1;
      tx_data_d = dout_alu;
    end else if (tx_ready) begin
      tx_v_d    = 1'b0;
      tx_data_d = '0;
    end

    if (take_pe) begin
      pe_v_d    = 1'b1;
      pe_data_d = dout_alu;
    end else if (out_ready) begin
      pe_v_d    = 1'b0;
      pe_data_d = '0;
    end
  end

  // State and datapath registers; reset discards any pending output word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      iter_cnt_q <= '0;
      last_q     <= '0;
      done_q     <= 1'b0;
      tx_v_q     <= 1'b0;
      tx_data_q  <= '0;
      pe_v_q     <= 1'b0;
      pe_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_cnt_q <= iter_cnt_d;
      last_q     <= last_d;
      done_q     <= done_d;
      tx_v_q     <= tx_v_d;
      tx_data_q  <= tx_data_d;
      pe_v_q     <= pe_v_d;
      pe_data_q  <= pe_data_d;
    end
  end

  assign load_v    = (state_q == S_LOAD);
  assign cmpt_v    = (state_q == S_COMPUTE);
  assign tx_ph     = (state_q == S_TRANSMIT);
  assign out_ph    = (state_q == S_OUTPUT);
  assign alu_hold  = (tx_ph && tx_v_q && !tx_ready) || (out_ph && pe_v_q && !out_ready);
  assign busy      = (state_q != S_IDLE) || tx_v_q || pe_v_q;
  assign iter_cnt  = iter_cnt_q;
  assign dout_tx_v = tx_v_q;
  assign dout_tx   = tx_data_q;
  assign dout_pe_v = pe_v_q;
  assign dout_pe   = pe_data_q;
  assign done      = done_q;

endmodule
